dmem_responder: RTL and testbench

Multi-cycle data-memory responder: the target end of the memory stage's load/store port. It accepts one request at a time over a valid/ready handshake, models a fixed access latency, and commits stores or returns load data. While an access is outstanding it drives a stall toward the hazard unit so the pipeline freezes in M. It replaces the single-cycle combinational data memory when the CPU is built with realistic memory timing.

---
 rtl/dmem_responder_pkg.sv | 64 ++++++
 rtl/dmem_responder_if.sv | 27 ++
 rtl/dmem_array.sv | 36 +++
 rtl/dmem_responder.sv | 121 ++++++++++++
 tb/tb_dmem_responder.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared encodings and lane helpers for the data-memory responder.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Contents: size encodings, FSM state encodings, default geometry/latency,
// the latched request struct and the alignment / byte-lane helpers.
package dmem_responder_pkg;

  // Access size as driven by the memory stage; 3 is reserved and behaves as word.
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Responder FSM states.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int DMEM_DEPTH_WORDS_DFLT = 1024;
  localparam int DMEM_LATENCY_DFLT     = 3;

  // Request fields captured at acceptance and held for the whole access.
  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

  // Half must be 2-byte aligned, word (and reserved size) 4-byte aligned.
  function automatic logic dmem_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = lo[0];
      default: mis = (lo != 2'b00);
    endcase
    return mis;
  endfunction

  // Byte enables for a store of the given size at the given low address bits.
  function automatic logic [3:0] dmem_lane_be(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << lo;
      SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data arrives right-aligned; replicate it so every enabled lane sees it.
  function automatic logic [31:0] dmem_lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] wd;
    case (size)
      SZ_BYTE: wd = {4{wdata[7:0]}};
      SZ_HALF: wd = {2{wdata[15:0]}};
      default: wd = wdata;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: load/store port between the memory stage and the data-memory responder.
// Latency: n/a (wires only).
// Backpressure: valid/ready on the request; response is a one-cycle pulse with no ready.
//
// master = memory stage (drives req_*), slave = responder (drives req_ready, resp_*, stall_M).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall_M;

  modport master (
    output req_valid, req_write, req_size, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall_M
  );

  modport slave (
    input  req_valid, req_write, req_size, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, stall_M
  );
endinterface

// File: rtl/dmem_array.sv
// dmem_array: DEPTH_WORDS x 32 storage, byte write enables, registered read.
// Latency: write and read both take effect on the enabling clock edge; read data valid the next cycle.
// Backpressure: none; accepts one operation per cycle.
//
// Ports: clk_i; we_i[3:0] byte enables; re_i read strobe; addr_i word index;
//        wdata_i lane-replicated store data; rdata_o word captured by the last read.
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic [3:0]    we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  // Contents start at zero and are deliberately outside the reset domain.
  logic [31:0] mem_q [DEPTH_WORDS] = '{default: '0};
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) begin
        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory target for the M-stage load/store port.
// Latency: LATENCY cycles from acceptance to the one-cycle resp_valid pulse.
// Backpressure: req_ready only in IDLE; stall_M holds the pipeline while an access is open.
//
// Ports: clk, reset (synchronous, active-high); bus = slave side of dmem_responder_if
//        (req_valid/write/size/addr/wdata in; req_ready, resp_valid/rdata/err, stall_M out).
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS_DFLT,
  parameter int LATENCY     = DMEM_LATENCY_DFLT
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  dmem_req_t     req_q, req_d;

  dmem_req_t     bus_req;
  dmem_req_t     acc_req;
  logic          accept;
  logic          commit;
  logic          acc_err;
  logic [3:0]    arr_we;
  logic          arr_re;
  logic [31:0]   arr_rdata;
  logic          resp_vld;
  logic          resp_mis;
  logic          unused_addr_hi;

  assign bus_req = '{write: bus.req_write, size: bus.req_size,
                     addr: bus.req_addr, wdata: bus.req_wdata};

  assign accept = bus.req_valid && (state_q == ST_IDLE);

  // commit marks the edge that enters RESP; that is where the array is touched.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          req_d = bus_req;
          cnt_d = CNT_LOAD;
          if (LATENCY == 1) begin
            state_d = ST_RESP;
            commit  = 1'b1;
          end else begin
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_RESP;
          commit  = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  // With LATENCY=1 the commit edge is the acceptance edge, so the fields come
  // straight off the bus; otherwise they come from the latched copy.
  assign acc_req = (state_q == ST_IDLE) ? bus_req : req_q;
  assign acc_err = dmem_misaligned(acc_req.size, acc_req.addr[1:0]);

  // Reset on the commit edge drops the access, so both strobes are qualified.
  assign arr_we = (commit && acc_req.write && !acc_err && !reset)
                ? dmem_lane_be(acc_req.size, acc_req.addr[1:0]) : 4'b0000;
  assign arr_re = commit && !acc_req.write && !reset;

  // Upper address bits are ignored: the array wraps modulo its size.
  assign unused_addr_hi = ^acc_req.addr[31:AW+2];

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk_i   (clk),
    .we_i    (arr_we),
    .re_i    (arr_re),
    .addr_i  (acc_req.addr[AW+1:2]),
    .wdata_i (dmem_lane_wdata(acc_req.size, acc_req.wdata)),
    .rdata_o (arr_rdata)
  );

  // A reset in RESP suppresses the pulse in that same cycle.
  assign resp_vld = (state_q == ST_RESP) && !reset;
  assign resp_mis = dmem_misaligned(req_q.size, req_q.addr[1:0]);

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.resp_valid = resp_vld;
  assign bus.resp_err   = resp_vld && resp_mis;
  assign bus.resp_rdata = (resp_vld && !req_q.write && !resp_mis) ? arr_rdata : 32'h0;
  assign bus.stall_M    = bus.req_valid && !resp_vld;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized + directed checks of dmem_responder against a word-array model.
// Latency: two instances, LATENCY=3 (index 0) and LATENCY=1 (index 1), DEPTH_WORDS=1024.
// Backpressure: every response is expected in exactly the cycle given by the latency.
module tb_dmem_responder;

  logic clk;
  logic rst;

  logic        d_valid [2];
  logic        d_write [2];
  logic [1:0]  d_size  [2];
  logic [31:0] d_addr  [2];
  logic [31:0] d_wdata [2];
  logic        o_ready [2];
  logic        o_rvalid[2];
  logic [31:0] o_rdata [2];
  logic        o_err   [2];
  logic        o_stall [2];

  dmem_responder_if if3();
  dmem_responder_if if1();

  assign if3.req_valid = d_valid[0];
  assign if3.req_write = d_write[0];
  assign if3.req_size  = d_size[0];
  assign if3.req_addr  = d_addr[0];
  assign if3.req_wdata = d_wdata[0];
  assign o_ready[0]    = if3.req_ready;
  assign o_rvalid[0]   = if3.resp_valid;
  assign o_rdata[0]    = if3.resp_rdata;
  assign o_err[0]      = if3.resp_err;
  assign o_stall[0]    = if3.stall_M;

  assign if1.req_valid = d_valid[1];
  assign if1.req_write = d_write[1];
  assign if1.req_size  = d_size[1];
  assign if1.req_addr  = d_addr[1];
  assign if1.req_wdata = d_wdata[1];
  assign o_ready[1]    = if1.req_ready;
  assign o_rvalid[1]   = if1.resp_valid;
  assign o_rdata[1]    = if1.resp_rdata;
  assign o_err[1]      = if1.resp_err;
  assign o_stall[1]    = if1.stall_M;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) u_dut3 (.clk(clk), .reset(rst), .bus(if3));
  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut1 (.clk(clk), .reset(rst), .bus(if1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference memory: one word array per instance, updated per byte rules.
  logic [31:0] mdl [2][1024];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit mdl_mis(input logic [1:0] sz, input logic [31:0] a);
    int lo = int'(a % 4);
    if (sz == 2'd0) return 1'b0;
    if (sz == 2'd1) return (lo % 2) != 0;
    return lo != 0;
  endfunction

  function automatic int mdl_idx(input logic [31:0] a);
    return int'((a / 4) % 1024);
  endfunction

  task automatic mdl_store(input int s, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int i = mdl_idx(a);
    int lo = int'(a % 4);
    logic [31:0] w = mdl[s][i];
    if (sz == 2'd0)      w[8*lo +: 8] = wd[7:0];
    else if (sz == 2'd1) w[8*lo +: 16] = wd[15:0];
    else                 w = wd;
    mdl[s][i] = w;
  endtask

  // Starts at posedge+1 of the request cycle T; returns at posedge+1 of T+lat+1
  // (hold=1, request left asserted) or one idle cycle later (hold=0).
  task automatic access(input int s, input logic wr, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input bit hold, output logic [31:0] got_rd);
    int lat = (s == 0) ? 3 : 1;
    bit exp_err = mdl_mis(sz, a);
    logic [31:0] exp_rd = (wr || exp_err) ? 32'h0 : mdl[s][mdl_idx(a)];
    got_rd = 32'h0;
    d_valid[s] = 1'b1;
    d_write[s] = wr;
    d_size[s]  = sz;
    d_addr[s]  = a;
    d_wdata[s] = wd;
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      if (k == 0) chk("req_ready_at_T", 32'(o_ready[s]), 32'd1);
      chk("resp_valid_timing", 32'(o_rvalid[s]), 32'(k == lat));
      chk("stall_M_timing", 32'(o_stall[s]), 32'(k != lat));
      if (k == lat) begin
        chk("resp_rdata", o_rdata[s], exp_rd);
        chk("resp_err", 32'(o_err[s]), 32'(exp_err));
        got_rd = o_rdata[s];
      end
      @(posedge clk); #1;
    end
    if (wr && !exp_err) mdl_store(s, sz, a, wd);
    if (!hold) begin
      d_valid[s] = 1'b0;
      @(negedge clk);
      chk("idle_ready", 32'(o_ready[s]), 32'd1);
      chk("idle_no_resp", 32'(o_rvalid[s]), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  // Store to 0x40 on the LATENCY=3 instance, reset asserted dly cycles after T.
  task automatic reset_abort(input int dly);
    d_valid[0] = 1'b1;
    d_write[0] = 1'b1;
    d_size[0]  = 2'd2;
    d_addr[0]  = 32'h40;
    d_wdata[0] = 32'h12345678;
    repeat (dly) begin
      @(negedge clk);
      chk("abort_pre_resp", 32'(o_rvalid[0]), 32'd0);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    d_valid[0] = 1'b0;
    @(negedge clk);
    chk("abort_resp_in_reset", 32'(o_rvalid[0]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready_after", 32'(o_ready[0]), 32'd1);
    repeat (4) begin
      chk("abort_no_resp", 32'(o_rvalid[0]), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 1024; i++) mdl[s][i] = 32'h0;
      d_valid[s] = 1'b1;
      d_write[s] = 1'b0;
      d_size[s]  = 2'd2;
      d_addr[s]  = 32'h0;
      d_wdata[s] = 32'h0;
    end
    rst = 1'b1;

    // Reset state; stall_M follows req_valid while no response is pending.
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_stall_follows_valid", 32'(o_stall[s]), 32'd1);
      chk("rst_resp_valid", 32'(o_rvalid[s]), 32'd0);
    end
    @(posedge clk); #1;
    d_valid[0] = 1'b0;
    d_valid[1] = 1'b0;
    @(negedge clk);
    chk("rst_stall_low", 32'(o_stall[0]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_req_ready", 32'(o_ready[s]), 32'd1);
      chk("rst_resp_rdata", o_rdata[s], 32'h0);
      chk("rst_resp_err", 32'(o_err[s]), 32'd0);
    end
    @(posedge clk); #1;

    // Word store / load.
    access(0, 1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 1'b0, rd);
    access(0, 1'b0, 2'd2, 32'h10, 32'h0, 1'b0, rd);
    chk("plan_word_load", rd, 32'hDEADBEEF);

    // Byte and half merges.
    access(0, 1'b1, 2'd2, 32'h10, 32'h11223344, 1'b0, rd);
    access(0, 1'b1, 2'd0, 32'h13, 32'h000000AB, 1'b0, rd);
    access(0, 1'b0, 2'd2, 32'h10, 32'h0, 1'b0, rd);
    chk("plan_byte_merge", rd, 32'hAB223344);
    access(0, 1'b1, 2'd1, 32'h12, 32'h00005566, 1'b0, rd);
    access(0, 1'b0, 2'd2, 32'h10, 32'h0, 1'b0, rd);
    chk("plan_half_merge", rd, 32'h55663344);

    // Misaligned accesses leave memory untouched.
    access(0, 1'b1, 2'd2, 32'h20, 32'h600DCAFE, 1'b0, rd);
    access(0, 1'b1, 2'd2, 32'h21, 32'hFFFFFFFF, 1'b0, rd);
    access(0, 1'b0, 2'd1, 32'h23, 32'h0, 1'b0, rd);
    access(0, 1'b0, 2'd3, 32'h20, 32'h0, 1'b0, rd);
    chk("plan_misaligned_nowrite", rd, 32'h600DCAFE);

    // Back-to-back with req_valid held across responses.
    access(0, 1'b1, 2'd2, 32'h30, 32'hA5A5_0001, 1'b1, rd);
    access(0, 1'b1, 2'd2, 32'h34, 32'hA5A5_0002, 1'b1, rd);
    access(0, 1'b0, 2'd2, 32'h30, 32'h0, 1'b1, rd);
    access(0, 1'b0, 2'd2, 32'h34, 32'h0, 1'b0, rd);
    chk("plan_b2b_load", rd, 32'hA5A5_0002);

    // Reset in BUSY, and reset on the commit edge.
    access(0, 1'b1, 2'd2, 32'h40, 32'hCAFEF00D, 1'b0, rd);
    reset_abort(1);
    access(0, 1'b0, 2'd2, 32'h40, 32'h0, 1'b0, rd);
    chk("plan_abort_busy", rd, 32'hCAFEF00D);
    reset_abort(2);
    access(0, 1'b0, 2'd2, 32'h40, 32'h0, 1'b0, rd);
    chk("plan_abort_commit_edge", rd, 32'hCAFEF00D);

    // LATENCY=1 and address wrap.
    access(1, 1'b1, 2'd2, 32'h1000, 32'h5A5AA5A5, 1'b0, rd);
    access(1, 1'b0, 2'd2, 32'h0, 32'h0, 1'b0, rd);
    chk("plan_wrap_lat1", rd, 32'h5A5AA5A5);

    // Random traffic over a few aliased words on each instance.
    for (int s = 0; s < 2; s++) begin
      for (int n = 0; n < 60; n++) begin
        a = ($urandom() & 32'hFFFF_F000) | 32'($urandom_range(0, 31));
        access(s, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom(),
               (n != 59) ? 1'($urandom_range(0, 1)) : 1'b0, rd);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
